// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage behind async_fifo. It pops one word whenever the
// FIFO reports non-empty while idle, then serialises the word as an async UART
// frame: a start bit, WIDTH data bits LSB first, an optional parity bit and one
// stop bit. It runs in the same clock domain as the FIFO read side.
//
// Build option:
//   FIFO_UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the data
//                           bits) is sent between the last data bit and the
//                           stop bit. When it is not defined, DATA goes
//                           straight to STOP.
//
// All outputs are registered. The next-state logic works out the state for the
// coming cycle, and the output registers are loaded from that value. As a
// result, tx, busy, fifo_rd_en and frame_done always line up with state_reg.
module fifo_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_POP    = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_START  = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif
   localparam logic [2:0] S_STOP   = 3'd6;

   logic [2:0]        state_reg, state_next;
   logic [BAUD_W-1:0] baud_reg, baud_next;
   logic [BIT_W-1:0]  bit_reg, bit_next;
   logic [WIDTH-1:0]  shift_reg, shift_next;
   logic              tx_reg, tx_next;
   logic              rd_en_reg, rd_en_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              baud_last;

`ifdef FIFO_UART_TX_PARITY_EN
   // The parity is captured from fifo_data in LOAD, together with the word, so
   // the parity bit does not depend on the shift register after it has been
   // shifted out.
   logic [WIDTH-1:0]  par_chain;
   logic              parity_reg, parity_next;

   assign par_chain[0] = fifo_data[0];

   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_par
         assign par_chain[gi] = par_chain[gi-1] ^ fifo_data[gi];
      end
   endgenerate
`endif

   // This marks the last clock of the current serial bit period.
   assign baud_last = (baud_reg == BAUD_LAST);

   // This block computes the next state, the counters and the shift register.
   always_comb begin
      state_next = state_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            // A pop is decided only here, so a flag that toggles mid-frame
            // cannot cause an extra pop.
            if (!fifo_empty) begin
               state_next = S_POP;
            end
         end
         S_POP: begin
            state_next = S_LOAD;
         end
         S_LOAD: begin
            // The FIFO presents the popped word during this cycle.
            state_next = S_START;
            shift_next = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_next = par_chain[WIDTH-1];
`endif
         end
         S_START: begin
            if (baud_last) begin
               state_next = S_DATA;
               bit_next   = '0;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               if (bit_reg == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end else begin
                  bit_next   = bit_reg + BIT_W'(1);
                  shift_next = shift_reg >> 1;
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               state_next = S_PARITY == state_reg ? S_STOP : state_reg;
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // The baud counter restarts on every state change and on every bit
   // boundary. It only counts in the timed states from START onwards.
   always_comb begin
      baud_next = baud_reg;
      if ((state_next != state_reg) || baud_last) begin
         baud_next = '0;
      end else if (state_reg >= S_START) begin
         baud_next = baud_reg + BAUD_W'(1);
      end
   end

   // The output values for the coming cycle are derived from the next state.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         S_START: tx_next = 1'b0;
         S_DATA:  tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase
      rd_en_next = (state_next == S_POP);
      busy_next  = (state_next != S_IDLE);
      done_next  = (state_next == S_STOP) && (baud_next == BAUD_LAST);
   end

   // This block holds the state and output registers. Reset from any state
   // returns the block to an idle line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
         rd_en_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
         rd_en_reg <= rd_en_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   assign fifo_rd_en = rd_en_reg;
   assign tx         = tx_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx (WIDTH=8, CLKS_PER_BIT=4).
// A queue stands in for the FIFO. A frame-level model predicts the outputs for
// every cycle from the cycle offset within a frame, and a few literal
// expectations pin down both the model and the DUT.
module tb_fifo_uart_tx;

   localparam int W = 8;
   localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = W + 3;
`else
   localparam int NB = W + 2;
`endif
   localparam int FRAME = NB * C;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_data = '0;
   logic         fifo_rd_en, tx, busy, frame_done;

   fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [W-1:0] q[$];

   // mt: -1 means idle; 0 is the pop cycle, 1 the load cycle, and
   // 2..FRAME+1 the frame itself.
   int           mt = -1;
   logic [W-1:0] mword = '0;

   logic check_en = 1'b0;
   logic glitch_on = 1'b0;
   logic rd_seen = 1'b0;
   int   cyc = 0;
   int   rd_cnt = 0;
   int   done_cnt = 0;
   int   in_frame = 0;
   int   start_cyc = 0;
   int   done_cyc = 0;
   int   last_len = 0;
   int   last_gap = 0;
   int   par_sample = 0;

   function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] w);
`ifdef FIFO_UART_TX_PARITY_EN
      return {1'b1, ^w, w, 1'b0};
`else
      return {1'b1, w, 1'b0};
`endif
   endfunction

   function automatic int exp_tx(input int t, input logic [W-1:0] w);
      logic [NB-1:0] fb;
      fb = frame_bits(w);
      if (t < 2) return 1;
      return int'(fb[(t - 2) / C]);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic clear_stats();
      rd_cnt   = 0;
      done_cnt = 0;
   endtask

   // Frame-level model: it advances on each edge, using the same fifo_empty
   // value that the DUT samples.
   always @(posedge clk) begin
      if (reset) begin
         mt <= -1;
      end else if (mt == -1) begin
         if (!fifo_empty) begin
            mt    <= 0;
            mword <= (q.size() > 0) ? q[0] : '0;
         end
      end else if (mt == FRAME + 1) begin
         mt <= -1;
      end else begin
         mt <= mt + 1;
      end
   end

   // FIFO stand-in: the word is popped on the edge that ends a read-enable
   // cycle. fifo_empty is truthful unless glitching is enabled mid-frame.
   always @(posedge clk) begin
      #1;
      if (rd_seen && q.size() > 0) fifo_data = q.pop_front();
      if (glitch_on && mt >= 1 && mt <= FRAME) fifo_empty = (cyc % 2 == 0);
      else fifo_empty = (q.size() == 0);
   end

   // Compare process plus measurements of frame length, gap and pulse counts.
   always @(negedge clk) begin
      cyc++;
      rd_seen = fifo_rd_en;
      if (check_en) begin
         chk("tx", int'(tx), exp_tx(mt, mword));
         chk("busy", int'(busy), (mt >= 0) ? 1 : 0);
         chk("rd_en", int'(fifo_rd_en), (mt == 0) ? 1 : 0);
         chk("frame_done", int'(frame_done), (mt == FRAME + 1) ? 1 : 0);
         if (fifo_rd_en) rd_cnt++;
         if (frame_done) begin
            done_cnt++;
            if (in_frame != 0) last_len = cyc - start_cyc + 1;
            in_frame = 0;
            done_cyc = cyc;
         end else if (!busy) begin
            in_frame = 0;
         end else if (in_frame == 0 && !tx) begin
            in_frame  = 1;
            start_cyc = cyc;
            last_gap  = cyc - done_cyc - 1;
         end
         if (in_frame != 0 && cyc - start_cyc == (W + 1) * C + 1) par_sample = int'(tx);
      end
   end

   initial begin
      logic [NB-1:0] lit;
      int exp7;
      int exp3;
      reset = 1'b1;
      @(posedge clk);
      #1 check_en = 1'b1;

      // These literals pin the model's frame layout.
`ifdef FIFO_UART_TX_PARITY_EN
      lit = 11'b10101001010;
      exp7 = 1;
      exp3 = 0;
`else
      lit = 10'b1101001010;
      exp7 = 1;
      exp3 = 1;
`endif
      chk("model_bits_a5", int'(frame_bits(8'hA5)), int'(lit));

      // Test 1: reset, then an empty FIFO for 50 cycles.
      step(2);
      reset = 1'b0;
      clear_stats();
      step(50);
      chk("t1_rd_pulses", rd_cnt, 0);
      chk("t1_tx_idle", int'(tx), 1);
      chk("t1_busy_idle", int'(busy), 0);
      $display("t1 idle: rd=%0d tx=%0d busy=%0d", rd_cnt, tx, busy);

      // Test 2: a single word, 0xA5.
      clear_stats();
      q.push_back(8'hA5);
      step(FRAME + 15);
      chk("t2_rd_pulses", rd_cnt, 1);
      chk("t2_done_pulses", done_cnt, 1);
      chk("t2_frame_len", last_len, (W + 2 + NB - W - 2) * C);
      $display("t2 word a5: rd=%0d done=%0d len=%0d", rd_cnt, done_cnt, last_len);

      // Test 3: words 0x00 and 0xFF sent back to back.
      clear_stats();
      q.push_back(8'h00);
      q.push_back(8'hFF);
      step(2 * FRAME + 20);
      chk("t3_rd_pulses", rd_cnt, 2);
      chk("t3_done_pulses", done_cnt, 2);
      chk("t3_gap", last_gap, 3);
      chk("t3_frame_len", last_len, FRAME);
      $display("t3 words 00,ff: rd=%0d done=%0d gap=%0d len=%0d", rd_cnt, done_cnt, last_gap, last_len);

      // Test 4: reset asserted in the middle of the data bits of 0x3C.
      clear_stats();
      q.push_back(8'h3C);
      step(16);
      chk("t4_busy_mid_data", int'(busy), 1);
      reset = 1'b1;
      step(1);
      chk("t4_tx_after_reset", int'(tx), 1);
      chk("t4_busy_after_reset", int'(busy), 0);
      reset = 1'b0;
      clear_stats();
      step(30);
      chk("t4_no_pop_while_empty", rd_cnt, 0);
      q.push_back(8'h5A);
      step(FRAME + 15);
      chk("t4_pop_after_refill", rd_cnt, 1);
      chk("t4_done_after_refill", done_cnt, 1);
      $display("t4 mid-frame reset: rd=%0d done=%0d", rd_cnt, done_cnt);

      // Test 5: the parity bit position for 0x07 and for 0x03.
      clear_stats();
      q.push_back(8'h07);
      step(FRAME + 15);
      chk("t5_bit9_07", par_sample, exp7);
      chk("t5_len_07", last_len, FRAME);
      q.push_back(8'h03);
      step(FRAME + 15);
      chk("t5_bit9_03", par_sample, exp3);
      chk("t5_len_03", last_len, FRAME);
      $display("t5 parity: bit9(03)=%0d len=%0d", par_sample, last_len);

      // Test 6: fifo_empty toggled during frames.
      clear_stats();
      glitch_on = 1'b1;
      q.push_back(8'h11);
      q.push_back(8'h22);
      step(2 * FRAME + 20);
      glitch_on = 1'b0;
      step(2);
      chk("t6_rd_pulses", rd_cnt, 2);
      chk("t6_done_pulses", done_cnt, 2);
      $display("t6 glitching empty: rd=%0d done=%0d", rd_cnt, done_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
